// File: rtl/encoder8_3_sync.sv
// Registered 8-to-3 priority encoder with a stability filter and a change strobe.
// Optional macro MULTI_HOT_ERR_EN adds a multi-hot flag to the key and to out_multi.
module encoder8_3_sync #(
    parameter int STABLE_CYC = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] in,
    output logic [2:0] out_code,
    output logic       out_active,
    output logic       out_valid,
    output logic       out_multi
);

`ifdef MULTI_HOT_ERR_EN
    localparam int KW = 5;
`else
    localparam int KW = 4;
`endif
    localparam int CW = $clog2(STABLE_CYC) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        UPDATE
    } state_t;

    logic [7:0]    sync1_reg;
    logic [7:0]    in_s_reg;
    state_t        state_reg, state_next;
    logic [KW-1:0] cand_reg, cand_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    out_code_reg, out_code_next;
    logic          out_active_reg, out_active_next;
    logic          out_valid_reg, out_valid_next;

    logic [7:0]    above;
    logic [7:0]    hi;
    logic [2:0]    enc;
    logic          any;
    logic [KW-1:0] key;
    logic [KW-1:0] pub_key;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_reg <= '0;
            in_s_reg  <= '0;
        end else begin
            sync1_reg <= in;
            in_s_reg  <= sync1_reg;
        end
    end

    // above[i] is set when some higher-priority line is also set
    assign above[7] = 1'b0;
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_above
            assign above[gi] = above[gi+1] | in_s_reg[gi+1];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_hi
            assign hi[gi] = in_s_reg[gi] & ~above[gi];
        end
    endgenerate

    always_comb begin
        enc = '0;
        for (int i = 0; i < 8; i++) begin
            if (hi[i]) enc = 3'(i);
        end
    end

    assign any = |in_s_reg;

`ifdef MULTI_HOT_ERR_EN
    logic multi;
    logic out_multi_reg, out_multi_next;

    // a set bit with another set bit above it means at least two bits are set
    assign multi   = |(in_s_reg & above);
    assign key     = {enc, any, multi};
    assign pub_key = {out_code_reg, out_active_reg, out_multi_reg};
    assign out_multi = out_multi_reg;
`else
    assign key     = {enc, any};
    assign pub_key = {out_code_reg, out_active_reg};
    assign out_multi = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            cand_reg       <= '0;
            cnt_reg        <= '0;
            out_code_reg   <= '0;
            out_active_reg <= 1'b0;
            out_valid_reg  <= 1'b0;
`ifdef MULTI_HOT_ERR_EN
            out_multi_reg  <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            cand_reg       <= cand_next;
            cnt_reg        <= cnt_next;
            out_code_reg   <= out_code_next;
            out_active_reg <= out_active_next;
            out_valid_reg  <= out_valid_next;
`ifdef MULTI_HOT_ERR_EN
            out_multi_reg  <= out_multi_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        cand_next       = cand_reg;
        cnt_next        = cnt_reg;
        out_code_next   = out_code_reg;
        out_active_next = out_active_reg;
        out_valid_next  = 1'b0;
`ifdef MULTI_HOT_ERR_EN
        out_multi_next  = out_multi_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (key != pub_key) begin
                    cand_next  = key;
                    cnt_next   = '0;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (key != cand_reg) begin
                    cand_next = key;
                    cnt_next  = '0;
                end else if (key == pub_key) begin
                    // bounce settled back on the already-published value
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = UPDATE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            UPDATE: begin
                out_code_next   = cand_reg[KW-1 -: 3];
                out_active_next = cand_reg[KW-4];
`ifdef MULTI_HOT_ERR_EN
                out_multi_next  = cand_reg[0];
`endif
                out_valid_next  = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_code   = out_code_reg;
    assign out_active = out_active_reg;
    assign out_valid  = out_valid_reg;

endmodule
